// File: rtl/sevseg_pkg.sv
// Shared constants for the seven-segment scan PIO: register map, control bits, hex decode table.
package sevseg_pkg;

    localparam int unsigned BUS_ADDR_W = 3;
    localparam int unsigned BUS_DATA_W = 32;

    localparam logic [BUS_ADDR_W-1:0] ADDR_DATA     = 3'd0;
    localparam logic [BUS_ADDR_W-1:0] ADDR_BLANK    = 3'd1;
    localparam logic [BUS_ADDR_W-1:0] ADDR_DP       = 3'd2;
    localparam logic [BUS_ADDR_W-1:0] ADDR_PRESCALE = 3'd3;
    localparam logic [BUS_ADDR_W-1:0] ADDR_CTRL     = 3'd4;
    localparam logic [BUS_ADDR_W-1:0] ADDR_STATUS   = 3'd5;

    localparam int unsigned CTRL_EN_BIT      = 0;
    localparam int unsigned CTRL_IRQ_EN_BIT  = 1;
    localparam int unsigned STATUS_FRAME_BIT = 0;

    // Active-high {g,f,e,d,c,b,a} for a hex nibble.
    function automatic logic [6:0] hex_seg(input logic [3:0] nib);
        logic [6:0] seg;
        seg = 7'h00;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/nios_sys_pio_sevseg_scan_if.sv
// Avalon-MM slave bus bundle for the seven-segment scan PIO.
interface nios_sys_pio_sevseg_scan_if;
    import sevseg_pkg::*;

    logic [BUS_ADDR_W-1:0] address;
    logic                  chipselect;
    logic                  write_n;
    logic [BUS_DATA_W-1:0] writedata;
    logic [BUS_DATA_W-1:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/sevseg_hex_decoder.sv
// Combinational nibble/dp/blank to active-high {dp,g..a} segment pattern.
module sevseg_hex_decoder
    import sevseg_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       dp_i,
    input  logic       blank_i,
    output logic [7:0] seg_o
);

    assign seg_o = blank_i ? 8'h00 : {dp_i, hex_seg(nibble_i)};

endmodule

// File: rtl/nios_sys_pio_sevseg_scan.sv
// Multi-digit multiplexed seven-segment PIO on the Avalon-MM bus.
// Define SEVSEG_IRQ_EN to build the frame STATUS flag and level interrupt.
module nios_sys_pio_sevseg_scan
    import sevseg_pkg::*;
#(
    parameter int unsigned           NUM_DIGITS       = 4,
    parameter int unsigned           PRESCALE_W       = 16,
    parameter logic [PRESCALE_W-1:0] DEFAULT_PRESCALE = PRESCALE_W'(4999),
    parameter bit                    SEG_ACTIVE_LOW   = 1'b1,
    parameter bit                    DIG_ACTIVE_LOW   = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    nios_sys_pio_sevseg_scan_if.slave     bus,
    output logic [7:0]                    seg_out,
    output logic [NUM_DIGITS-1:0]         dig_sel,
    output logic                          irq
);

    localparam int unsigned           DATA_W   = 4 * NUM_DIGITS;
    localparam int unsigned           IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [7:0]            SEG_OFF  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF  = DIG_ACTIVE_LOW ? '1 : '0;

    logic [DATA_W-1:0]     data_q;
    logic [NUM_DIGITS-1:0] blank_q;
    logic [NUM_DIGITS-1:0] dp_q;
    logic [PRESCALE_W-1:0] prescale_q;
    logic                  en_q;
    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [7:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] dig_q, dig_d;

    logic                  wr_c;
    logic                  adv_c;
    logic [3:0]            nib_c;
    logic                  blank_c;
    logic                  dp_c;
    logic [NUM_DIGITS-1:0] hot_c;
    logic [7:0]            seg_hi_c;
    logic                  irq_en_rd_c;
    logic                  frame_rd_c;
    logic                  unused_wdata_c;

    assign wr_c           = bus.chipselect && !bus.write_n;
    assign adv_c          = en_q && (cnt_q == '0);
    assign unused_wdata_c = ^bus.writedata;

    // Scan counter: held loaded while disabled so enabling gives a full first dwell.
    always_comb begin
        cnt_d = prescale_q;
        idx_d = '0;
        if (en_q) begin
            if (adv_c) begin
                cnt_d = prescale_q;
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            end else begin
                cnt_d = cnt_q - PRESCALE_W'(1);
                idx_d = idx_q;
            end
        end
    end

    always_comb begin
        nib_c   = 4'h0;
        blank_c = 1'b1;
        dp_c    = 1'b0;
        hot_c   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib_c    = data_q[4*i +: 4];
                blank_c  = blank_q[i];
                dp_c     = dp_q[i];
                hot_c[i] = 1'b1;
            end
        end
    end

    sevseg_hex_decoder u_dec (
        .nibble_i (nib_c),
        .dp_i     (dp_c),
        .blank_i  (blank_c),
        .seg_o    (seg_hi_c)
    );

    // Polarity applied by XOR with the inactive level.
    always_comb begin
        seg_d = (en_q ? seg_hi_c : 8'h00) ^ SEG_OFF;
        dig_d = ((en_q && !blank_c) ? hot_c : '0) ^ DIG_OFF;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q     <= '0;
            blank_q    <= '1;
            dp_q       <= '0;
            prescale_q <= DEFAULT_PRESCALE;
            en_q       <= 1'b0;
            cnt_q      <= DEFAULT_PRESCALE;
            idx_q      <= '0;
            seg_q      <= SEG_OFF;
            dig_q      <= DIG_OFF;
        end else begin
            if (wr_c) begin
                case (bus.address)
                    ADDR_DATA:     data_q     <= bus.writedata[DATA_W-1:0];
                    ADDR_BLANK:    blank_q    <= bus.writedata[NUM_DIGITS-1:0];
                    ADDR_DP:       dp_q       <= bus.writedata[NUM_DIGITS-1:0];
                    ADDR_PRESCALE: prescale_q <= bus.writedata[PRESCALE_W-1:0];
                    ADDR_CTRL:     en_q       <= bus.writedata[CTRL_EN_BIT];
                    default:       ;
                endcase
            end
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            seg_q <= seg_d;
            dig_q <= dig_d;
        end
    end

    assign seg_out = seg_q;
    assign dig_sel = dig_q;

`ifdef SEVSEG_IRQ_EN
    logic irq_en_q;
    logic frame_q;
    logic irq_q;
    logic frame_ev_c;

    assign frame_ev_c = adv_c && (idx_q == IDX_LAST);

    // A frame event on the same edge as a W1C keeps FRAME set.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en_q <= 1'b0;
            frame_q  <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (wr_c && (bus.address == ADDR_CTRL)) begin
                irq_en_q <= bus.writedata[CTRL_IRQ_EN_BIT];
            end
            if (frame_ev_c) begin
                frame_q <= 1'b1;
            end else if (wr_c && (bus.address == ADDR_STATUS) && bus.writedata[STATUS_FRAME_BIT]) begin
                frame_q <= 1'b0;
            end
            irq_q <= frame_q & irq_en_q;
        end
    end

    assign irq_en_rd_c = irq_en_q;
    assign frame_rd_c  = frame_q;
    assign irq         = irq_q;
`else
    assign irq_en_rd_c = 1'b0;
    assign frame_rd_c  = 1'b0;
    assign irq         = 1'b0;
`endif

    // Read mux is purely address-driven, zero wait states.
    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_DATA:     bus.readdata = BUS_DATA_W'(data_q);
            ADDR_BLANK:    bus.readdata = BUS_DATA_W'(blank_q);
            ADDR_DP:       bus.readdata = BUS_DATA_W'(dp_q);
            ADDR_PRESCALE: bus.readdata = BUS_DATA_W'(prescale_q);
            ADDR_CTRL: begin
                bus.readdata[CTRL_EN_BIT]     = en_q;
                bus.readdata[CTRL_IRQ_EN_BIT] = irq_en_rd_c;
            end
            ADDR_STATUS:   bus.readdata[STATUS_FRAME_BIT] = frame_rd_c;
            default:       bus.readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_nios_sys_pio_sevseg_scan.sv
// Scoreboard bench for nios_sys_pio_sevseg_scan (4 digits, active-low segments and digits).
module tb_nios_sys_pio_sevseg_scan;
    import sevseg_pkg::*;

    typedef struct packed {
        logic [7:0] seg;
        logic [3:0] dig;
        logic       irq;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] seg_out;
    logic [3:0] dig_sel;
    logic       irq;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    nios_sys_pio_sevseg_scan_if bus ();

    nios_sys_pio_sevseg_scan #(
        .NUM_DIGITS       (4),
        .PRESCALE_W       (16),
        .DEFAULT_PRESCALE (16'd4999),
        .SEG_ACTIVE_LOW   (1'b1),
        .DIG_ACTIVE_LOW   (1'b1)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.slave),
        .seg_out (seg_out),
        .dig_sel (dig_sel),
        .irq     (irq)
    );

    function automatic logic [6:0] ref_hex(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return t[n];
    endfunction

    function automatic exp_t off_exp(input logic irq_v);
        exp_t e;
        e.seg = 8'hFF;
        e.dig = 4'hF;
        e.irq = irq_v;
        return e;
    endfunction

    function automatic exp_t digit_exp(input int d, input logic [15:0] data,
                                       input logic [3:0] blank, input logic [3:0] dp,
                                       input logic irq_v);
        exp_t       e;
        logic [3:0] nib;
        logic [3:0] one;
        nib = data[4*d +: 4];
        one = 4'b0001 << d;
        if (blank[d]) begin
            e = off_exp(irq_v);
        end else begin
            e.seg = ~{dp[d], ref_hex(nib)};
            e.dig = ~one;
            e.irq = irq_v;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
        bus.address    = addr;
        bus.writedata  = data;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic setup(input logic [15:0] pre, input logic [15:0] data,
                         input logic [3:0] blank, input logic [3:0] dp);
        bus_write(ADDR_CTRL, 32'd0);
        bus_write(ADDR_PRESCALE, 32'(pre));
        bus_write(ADDR_DATA, 32'(data));
        bus_write(ADDR_BLANK, 32'(blank));
        bus_write(ADDR_DP, 32'(dp));
    endtask

    task automatic test_reset();
        logic [31:0] want [8];
        want = '{32'd0, 32'hF, 32'd0, 32'd4999, 32'd0, 32'd0, 32'd0, 32'd0};
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        n_vec++;
        if ({seg_out, dig_sel, irq} !== {8'hFF, 4'hF, 1'b0}) begin
            n_err++;
            $display("FAIL reset_outputs got seg=%h dig=%h irq=%b want seg=ff dig=f irq=0", seg_out, dig_sel, irq);
        end
        bus_write(3'd6, 32'hFFFF_FFFF);
        for (int a = 0; a < 8; a++) begin
            bus.address = 3'(a);
            #1;
            n_vec++;
            if (bus.readdata !== want[a]) begin
                n_err++;
                $display("FAIL reset_read addr=%0d got %h want %h", a, bus.readdata, want[a]);
            end
        end
    endtask

    task automatic test_scan();
        exp_t e;
        setup(16'd2, 16'h1234, 4'h0, 4'h0);
        exp_q.push_back(off_exp(1'b0));
        for (int k = 1; k <= 15; k++)
            exp_q.push_back(digit_exp(((k - 1) / 3) % 4, 16'h1234, 4'h0, 4'h0, 1'b0));
        for (int k = 0; k <= 15; k++) begin
            if (k == 0) bus_write(ADDR_CTRL, 32'd1);
            else        tick();
            e = exp_q.pop_front();
            n_vec++;
            if ({seg_out, dig_sel, irq} !== {e.seg, e.dig, e.irq}) begin
                n_err++;
                $display("FAIL scan k=%0d got %h/%h/%b want %h/%h/%b", k, seg_out, dig_sel, irq, e.seg, e.dig, e.irq);
            end
        end
    endtask

    task automatic test_blank_dp();
        exp_t e;
        setup(16'd0, 16'h1234, 4'b0010, 4'b0001);
        exp_q.push_back(off_exp(1'b0));
        for (int k = 1; k <= 8; k++)
            exp_q.push_back(digit_exp((k - 1) % 4, 16'h1234, 4'b0010, 4'b0001, 1'b0));
        for (int k = 0; k <= 8; k++) begin
            if (k == 0) bus_write(ADDR_CTRL, 32'd1);
            else        tick();
            e = exp_q.pop_front();
            n_vec++;
            if ({seg_out, dig_sel, irq} !== {e.seg, e.dig, e.irq}) begin
                n_err++;
                $display("FAIL blank_dp k=%0d got %h/%h/%b want %h/%h/%b", k, seg_out, dig_sel, irq, e.seg, e.dig, e.irq);
            end
        end
    endtask

    task automatic test_data_update();
        exp_t e;
        setup(16'd5, 16'h1234, 4'h0, 4'h0);
        exp_q.push_back(off_exp(1'b0));
        for (int k = 1; k <= 12; k++)
            exp_q.push_back(digit_exp((k - 1) / 6, (k >= 4) ? 16'hFFFF : 16'h1234, 4'h0, 4'h0, 1'b0));
        for (int k = 0; k <= 12; k++) begin
            if (k == 0)      bus_write(ADDR_CTRL, 32'd1);
            else if (k == 3) bus_write(ADDR_DATA, 32'h0000_FFFF);
            else             tick();
            e = exp_q.pop_front();
            n_vec++;
            if ({seg_out, dig_sel, irq} !== {e.seg, e.dig, e.irq}) begin
                n_err++;
                $display("FAIL data_update k=%0d got %h/%h/%b want %h/%h/%b", k, seg_out, dig_sel, irq, e.seg, e.dig, e.irq);
            end
        end
    endtask

    task automatic test_disable();
        exp_t e;
        setup(16'd1, 16'h1234, 4'h0, 4'h0);
        exp_q.push_back(off_exp(1'b0));
        for (int k = 1; k <= 13; k++) begin
            if (k <= 6)      exp_q.push_back(digit_exp((k - 1) / 2, 16'h1234, 4'h0, 4'h0, 1'b0));
            else if (k <= 9) exp_q.push_back(off_exp(1'b0));
            else             exp_q.push_back(digit_exp((k - 10) / 2, 16'h1234, 4'h0, 4'h0, 1'b0));
        end
        for (int k = 0; k <= 13; k++) begin
            if (k == 0 || k == 9) bus_write(ADDR_CTRL, 32'd1);
            else if (k == 6)      bus_write(ADDR_CTRL, 32'd0);
            else                  tick();
            e = exp_q.pop_front();
            n_vec++;
            if ({seg_out, dig_sel, irq} !== {e.seg, e.dig, e.irq}) begin
                n_err++;
                $display("FAIL disable k=%0d got %h/%h/%b want %h/%h/%b", k, seg_out, dig_sel, irq, e.seg, e.dig, e.irq);
            end
        end
    endtask

    task automatic test_irq();
        exp_t e;
        logic iv;
        setup(16'd0, 16'h1234, 4'h0, 4'h0);
        bus_write(ADDR_STATUS, 32'd1);
        bus.address = ADDR_STATUS;
        #1;
        n_vec++;
        if (bus.readdata !== 32'd0) begin
            n_err++;
            $display("FAIL irq_status_clear got %h want 0", bus.readdata);
        end
`ifdef SEVSEG_IRQ_EN
        exp_q.push_back(off_exp(1'b0));
        for (int k = 1; k <= 13; k++) begin
            iv = ((k >= 5) && (k <= 9)) || (k == 13);
            exp_q.push_back(digit_exp((k - 1) % 4, 16'h1234, 4'h0, 4'h0, iv));
        end
        for (int k = 0; k <= 13; k++) begin
            if (k == 0)                bus_write(ADDR_CTRL, 32'd3);
            else if (k == 8 || k == 9) bus_write(ADDR_STATUS, 32'd1);
            else                       tick();
            e = exp_q.pop_front();
            n_vec++;
            if ({seg_out, dig_sel, irq} !== {e.seg, e.dig, e.irq}) begin
                n_err++;
                $display("FAIL irq k=%0d got %h/%h/%b want %h/%h/%b", k, seg_out, dig_sel, irq, e.seg, e.dig, e.irq);
            end
        end
        bus.address = ADDR_CTRL;
        #1;
        n_vec++;
        if (bus.readdata !== 32'd3) begin
            n_err++;
            $display("FAIL irq_ctrl_read got %h want 3", bus.readdata);
        end
`else
        iv = 1'b0;
        exp_q.push_back(off_exp(iv));
        for (int k = 1; k <= 9; k++)
            exp_q.push_back(digit_exp((k - 1) % 4, 16'h1234, 4'h0, 4'h0, iv));
        for (int k = 0; k <= 9; k++) begin
            if (k == 0) bus_write(ADDR_CTRL, 32'd3);
            else        tick();
            e = exp_q.pop_front();
            n_vec++;
            if ({seg_out, dig_sel, irq} !== {e.seg, e.dig, e.irq}) begin
                n_err++;
                $display("FAIL noirq k=%0d got %h/%h/%b want %h/%h/%b", k, seg_out, dig_sel, irq, e.seg, e.dig, e.irq);
            end
        end
        bus.address = ADDR_CTRL;
        #1;
        n_vec++;
        if (bus.readdata !== 32'd1) begin
            n_err++;
            $display("FAIL noirq_ctrl_read got %h want 1", bus.readdata);
        end
        bus.address = ADDR_STATUS;
        #1;
        n_vec++;
        if (bus.readdata !== 32'd0) begin
            n_err++;
            $display("FAIL noirq_status_read got %h want 0", bus.readdata);
        end
`endif
    endtask

    task automatic test_reset_mid();
        logic [31:0] want [6];
        want = '{32'd0, 32'hF, 32'd0, 32'd4999, 32'd0, 32'd0};
        setup(16'd1, 16'h5A5A, 4'h0, 4'hF);
        bus_write(ADDR_CTRL, 32'd1);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        n_vec++;
        if ({seg_out, dig_sel, irq} !== {8'hFF, 4'hF, 1'b0}) begin
            n_err++;
            $display("FAIL reset_mid_outputs got seg=%h dig=%h irq=%b want ff/f/0", seg_out, dig_sel, irq);
        end
        reset = 1'b0;
        for (int a = 0; a < 6; a++) begin
            bus.address = 3'(a);
            #1;
            n_vec++;
            if (bus.readdata !== want[a]) begin
                n_err++;
                $display("FAIL reset_mid_read addr=%0d got %h want %h", a, bus.readdata, want[a]);
            end
        end
    endtask

    initial begin
        reset          = 1'b1;
        bus.address    = 3'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'd0;
        test_reset();
        test_scan();
        test_blank_dp();
        test_data_update();
        test_disable();
        test_irq();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
